mem_arbiter: RTL
================

# mem_arbiter

Two-port round-robin arbiter that shares the single 16-bit synchronous memory between the processor core (port 0) and a loader/debug master (port 1). It sits between the requesters and the memory pins (`we`, `addr`, write data, read data) and serialises all accesses. Each transfer uses a req/ack handshake. Port 1 can hold the memory across consecutive transfers with a bounded lock.

## Interface
Parameters:
- `AW`, 16: address width.
- `DW`, 16: data width.
- `MAX_LOCK`, 8: maximum consecutive lock-extended grants to port 1 while port 0 is requesting. Range 1..255.

Ports:
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `p0_req` in 1: port 0 transfer request. Held until `p0_ack`.
- `p0_we` in 1: port 0 write (1) or read (0). Held stable while `p0_req` is high.
- `p0_addr` in AW: port 0 address.
- `p0_wdata` in DW: port 0 write data.
- `p0_ack` out 1: one-cycle completion pulse to port 0.
- `p0_rdata` out DW: port 0 read data. Valid in the `p0_ack` cycle and held until the next port 0 read completes.
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_ack`, `p1_rdata`: same meanings as the port 0 signals, for port 1.
- `p1_lock` in 1: port 1 requests to keep ownership for its next transfer.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data. Valid the cycle after `mem_addr` is presented.
- `gnt` out 2: one-hot current owner. 00 when idle.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - No request: stay in IDLE, `gnt`=00.
  - Requests present: pick a winner, register its `we/addr/wdata` onto the `mem_*` outputs, set `gnt`, go to ACCESS.
- **Round-robin rule**
  - Both ports requesting: the port that did not win the last grant wins.
  - `last` resets to port 1, so port 0 wins the first contention.
- **Lock rule**
  - Applies when `last`=port 1, `p1_lock`=1 and `p1_req`=1: port 1 wins even if `p0_req`=1.
  - `lock_cnt` (8 bit) increments on each such lock-extended grant made while `p0_req`=1.
  - When `lock_cnt`=MAX_LOCK, the lock is ignored and port 0 wins. `lock_cnt` then clears.
  - `lock_cnt` also clears on any port 0 grant and on any grant where `p1_lock`=0.
- **ACCESS**
  - Memory samples `mem_addr/mem_we/mem_wdata` at the end of this cycle.
  - Go to RESP.
- **RESP**
  - `mem_we` returns to 0.
  - On a read, capture `mem_rdata` into the owner's `pX_rdata`. Writes leave `pX_rdata` unchanged.
  - Pulse the owner's `pX_ack` for exactly this cycle.
  - Update `last` to the owner. Go to IDLE.
- Requester rules:
  - `req` and its fields must stay stable from assertion until the ack cycle.
  - `req` may be kept high after ack to request a new transfer. IDLE samples it next cycle.
- The non-owner's request is never dropped. It is served when the arbiter next returns to IDLE.
- `mem_addr` and `mem_wdata` hold their last values in IDLE. Only `mem_we` is forced to 0.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `p0_ack`=`p1_ack`=0, `p0_rdata`=`p1_rdata`=0, `gnt`=00, `busy`=0. Internal: state=IDLE, `last`=port 1, `lock_cnt`=0.
- Latency: `req` seen in IDLE at cycle N. `mem_*` are driven during cycle N+1 (ACCESS). `ack` and `rdata` are valid in cycle N+2 (RESP).
- Throughput: one transfer per 3 cycles. No back-to-back ACCESS states.
- `mem_we` is high for exactly one cycle per write, the ACCESS cycle.
- Simultaneous `p0_req` and `p1_req` rise in IDLE: resolved by `last` and the lock rule in the same cycle. Exactly one `gnt` bit is set.
- Owner deasserting `req` mid-transfer is illegal. The arbiter completes the transfer and acks anyway.
- `rst` asserted in any state: all outputs go to reset values immediately (asynchronous). An in-flight transfer is aborted with no ack and `mem_we` drops in the same cycle.
- After reset deasserts, the first eligible edge is in IDLE.

## Test plan
- **Single read:** port 0 reads addr 0x0005 while memory holds 0xBEEF there. `mem_addr`=0x0005 in cycle N+1; `p0_ack`=1 and `p0_rdata`=0xBEEF in cycle N+2; `gnt`=01 during ACCESS and RESP.
- **Single write:** port 1 writes 0x1234 to 0x0010. `mem_we`=1 for exactly one cycle with `mem_addr`=0x0010 and `mem_wdata`=0x1234; `p1_ack` in N+2; `p1_rdata` unchanged.
- **Contention from reset:** both ports request continuously, no lock. Grants alternate 0,1,0,1; every transfer gets exactly one ack, 3 cycles apart.
- **Lock starvation bound:** `p1_lock`=1 with both requesting, MAX_LOCK=3. Port 1 wins once by round-robin plus 3 lock-extended grants, then port 0 is granted; `lock_cnt` returns to 0.
- **Back-to-back same port:** port 0 keeps `req` high for 4 reads of addresses 0..3 while port 1 is idle. Acks arrive at cycles 2, 5, 8, 11 with the correct data.
- **Reset mid-transfer:** assert `rst` during ACCESS of a port 0 write. `mem_we` drops immediately; no `p0_ack`; all outputs at reset values. After release, a fresh port 0 request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one 16-bit synchronous memory between the processor core (port 0)
// and a loader/debug master (port 1). Every transfer takes three cycles:
// IDLE (arbitrate) -> ACCESS (memory samples mem_*) -> RESP (ack + read data).
// Contention is resolved round-robin. Port 1 may hold the memory with p1_lock,
// but only for MAX_LOCK consecutive lock-extended grants while port 0 waits.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   pX_req/we/addr/wdata       port X request and its held transfer fields
//   pX_ack                     one-cycle completion pulse (RESP cycle)
//   pX_rdata                   read data, valid in the ack cycle, then held
//   p1_lock                    port 1 wants to keep ownership for its next transfer
//   mem_we/addr/wdata          memory pins, driven during ACCESS
//   mem_rdata                  memory read data, valid the cycle after mem_addr
//   gnt                        one-hot current owner, 00 when idle
//   busy                       high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    input  logic          p1_lock,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    gnt,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    state_t          state_q, state_d;
    logic            last_q, last_d;          // port that won the last completed grant
    logic [7:0]      lock_cnt_q, lock_cnt_d;
    logic            owner_q, owner_d;
    logic            xfer_we_q, xfer_we_d;    // direction of the transfer in flight
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [1:0]      gnt_q, gnt_d;

    logic            win;
    logic            lock_hit;
    logic [1:0]      ack_w;
    logic [1:0][DW-1:0] rdata_w;

    // -------------------------------------------------------------------------
    // Next-state / arbitration
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        lock_cnt_d  = lock_cnt_q;
        owner_d     = owner_q;
        xfer_we_d   = xfer_we_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        gnt_d       = gnt_q;
        win         = 1'b0;
        lock_hit    = 1'b0;

        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    // Lock only counts while the counter has headroom; at
                    // MAX_LOCK it is ignored so port 0 cannot starve.
                    lock_hit = last_q && p1_lock && p1_req && (lock_cnt_q != MAX_LOCK_C);
                    if (!p1_req) begin
                        win = 1'b0;
                    end else if (!p0_req) begin
                        win = 1'b1;
                    end else if (lock_hit) begin
                        win = 1'b1;
                    end else begin
                        win = ~last_q;
                    end

                    owner_d     = win;
                    xfer_we_d   = win ? p1_we    : p0_we;
                    mem_we_d    = win ? p1_we    : p0_we;
                    mem_addr_d  = win ? p1_addr  : p0_addr;
                    mem_wdata_d = win ? p1_wdata : p0_wdata;
                    gnt_d       = win ? 2'b10 : 2'b01;
                    state_d     = ACCESS;

                    // Only a grant that beat a waiting port 0 because of the
                    // lock advances the counter; a lone port 1 grant holds it.
                    if (!win || !p1_lock) begin
                        lock_cnt_d = 8'd0;
                    end else if (lock_hit && p0_req) begin
                        lock_cnt_d = lock_cnt_q + 8'd1;
                    end
                end
            end
            ACCESS: begin
                mem_we_d = 1'b0;
                state_d  = RESP;
            end
            RESP: begin
                last_d  = owner_q;
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: begin
                mem_we_d = 1'b0;
                gnt_d    = 2'b00;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            lock_cnt_q  <= 8'd0;
            owner_q     <= 1'b0;
            xfer_we_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            gnt_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            lock_cnt_q  <= lock_cnt_d;
            owner_q     <= owner_d;
            xfer_we_q   <= xfer_we_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            gnt_q       <= gnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Per-port ack and read-data holding registers
    // -------------------------------------------------------------------------
    // Read data is passed straight through from mem_rdata in the RESP cycle so
    // it is valid alongside ack, and the same value is captured for holding.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DW-1:0] rdata_q, rdata_d;

            assign ack_w[gi] = (state_q == RESP) && (owner_q == 1'(gi));

            always_comb begin
                rdata_d = rdata_q;
                if (ack_w[gi] && !xfer_we_q) begin
                    rdata_d = mem_rdata;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= rdata_d;
                end
            end

            assign rdata_w[gi] = rdata_d;
        end
    endgenerate

    assign p0_ack    = ack_w[0];
    assign p1_ack    = ack_w[1];
    assign p0_rdata  = rdata_w[0];
    assign p1_rdata  = rdata_w[1];
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign gnt       = gnt_q;
    assign busy      = (state_q != IDLE);

endmodule
